alu_exec_unit: RTL and testbench

Sequential execution unit that consumes the 3-bit ALU control code and performs the selected operation on two operands. It is the downstream end of the opcode-to-ALU-control decode in the multicycle datapath. Arithmetic and logic operations complete in one cycle. LSL and LSR shift one bit per cycle. Operands are accepted, and the result is returned, over separate valid/ready handshakes, with one operation in flight at a time.

---
 rtl/alu_exec_unit.sv | 99 +++++++++
 tb/tb_alu_exec_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Sequential ALU execution unit: single-cycle add/sub/xor/or, bit-serial LSL/LSR,
// with valid/ready handshakes on operands and result, one operation in flight.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ALU_ILL  = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_SUB  = 3'b011,
    ALU_ADD2 = 3'b100,
    ALU_OR   = 3'b101,
    ALU_LSL  = 3'b110,
    ALU_LSR  = 3'b111
  } alu_op_t;

  state_t           state;
  alu_op_t          op;
  logic [WIDTH-1:0] result_reg;
  logic [SHW-1:0]   cnt;
  logic             err_reg;
  logic             shift_left;

  assign op = alu_op_t'(alu_control);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      result_reg <= '0;
      cnt        <= '0;
      err_reg    <= 1'b0;
      shift_left <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            err_reg <= 1'b0;
            state   <= DONE;
            unique case (op)
              ALU_ADD, ALU_ADD2: result_reg <= op_a + op_b;
              ALU_XOR:           result_reg <= op_a ^ op_b;
              ALU_SUB:           result_reg <= op_a - op_b;
              ALU_OR:            result_reg <= op_a | op_b;
              ALU_LSL, ALU_LSR: begin
                result_reg <= op_a;
                cnt        <= op_b[SHW-1:0];
                shift_left <= (op == ALU_LSL);
                // A zero shift amount completes immediately with the operand unchanged.
                if (op_b[SHW-1:0] != '0) state <= SHIFT;
              end
              ALU_ILL: begin
                result_reg <= '0;
                err_reg    <= 1'b1;
              end
            endcase
          end
        end
        SHIFT: begin
          result_reg <= shift_left ? (result_reg << 1) : (result_reg >> 1);
          cnt        <= cnt - SHW'(1);
          if (cnt == SHW'(1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rst_n gates in_ready so the unit never advertises readiness while held in reset.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_reg;
  assign zero      = out_valid && (result_reg == '0);
  assign err       = out_valid && err_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized operations
// checked against a behavioural model of result, flags and latency.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] code, input logic [31:0] a,
                                             input logic [31:0] b);
    int s;
    s = b % 32;
    case (code)
      3'd1, 3'd4: return a + b;
      3'd2:       return a ^ b;
      3'd3:       return a - b;
      3'd5:       return a | b;
      3'd6:       return a << s;
      3'd7:       return a >> s;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] code, input logic [31:0] b);
    if (code == 3'd6 || code == 3'd7) return b % 32;
    return 0;
  endfunction

  // One full transaction: issue, wait for completion, optional backpressure, hand off.
  task automatic do_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                       input int stall);
    logic [31:0] exp_r;
    int          exp_lat;
    int          lat;
    exp_r   = ref_result(code, a, b);
    exp_lat = ref_latency(code, b);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; alu_control = code; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_control = 3'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("result", result, exp_r);
    check("zero", zero, exp_r == 32'd0);
    check("err", err, code == 3'd0);
    check("in_ready_busy", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = (i == 2) ? 1'b1 : 1'($urandom);
      check("hold_result", result, exp_r);
      check("hold_valid", out_valid, 1);
      check("hold_err", err, code == 3'd0);
      check("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_valid", out_valid, 0);
    check("handoff_in_ready", in_ready, 1);
  endtask

  initial begin
    int hs;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 3'd0; op_a = '0; op_b = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;

    do_op(3'b001, 32'd5, 32'd7, 0);
    do_op(3'b100, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(3'b011, 32'd9, 32'd9, 0);
    do_op(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    do_op(3'b101, 32'h00FF_0000, 32'h0000_FF00, 0);
    do_op(3'b110, 32'd1, 32'd31, 0);
    do_op(3'b111, 32'h8000_0000, 32'd36, 0);
    do_op(3'b110, 32'hDEAD_BEEF, 32'd0, 0);
    do_op(3'b001, 32'h1234_5678, 32'h1111_1111, 10);
    do_op(3'b000, 32'd7, 32'd7, 0);
    do_op(3'b001, 32'd1, 32'd1, 0);

    // Reset while shifting discards the operation.
    @(negedge clk);
    in_valid = 1'b1; alu_control = 3'b110; op_a = 32'h0000_0F0F; op_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_result", result, 0);
    check("midrst_zero", zero, 0);
    check("midrst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;
    do_op(3'b001, 32'd2, 32'd3, 0);

    // Throughput with both sides always willing: one result every 2 cycles.
    @(negedge clk);
    in_valid = 1'b1; alu_control = 3'b001; op_a = 32'd10; op_b = 32'd20; out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        hs++;
        check("b2b_result", result, 32'd30);
      end
    end
    check("b2b_count", hs, 10);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;

    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
